mult_hilo_ctrl: RTL and testbench
=================================

// Module: mult_hilo_ctrl
// PURPOSE
//   Front end for the sequential shift-add multiplier (St/Idle/Done handshake, 16x16->32 product).
//   Accepts MULT/MFHI/MFLO/MTHI/MTLO ops from the MIPS execute stage and launches the multiplier.
//   Captures the multiplier's product into HI/LO.
//   Stalls the pipeline while a multiply is in flight.
// PARAMETERS
//   WIDTH           16  operand width; HI and LO are each WIDTH bits, product is 2*WIDTH
//   TIMEOUT_CYCLES  64  max cycles in WAIT without MulDone before abort (8-bit counter)
// PORTS
//   Clk          in   1        rising-edge clock
//   Rst          in   1        asynchronous, active-high reset; the multiplier shares it
//   OpValid      in   1        op present this cycle
//   OpCode       in   3        0 NOP, 1 MULT, 2 MFHI, 3 MFLO, 4 MTHI, 5 MTLO, 6-7 treated as NOP
//   OpA          in   WIDTH    rs value (multiplicand / MTHI-MTLO source)
//   OpB          in   WIDTH    rt value (multiplier)
//   Stall        out  1        op not accepted this cycle; hold Op* stable
//   RdData       out  WIDTH    MFHI/MFLO result
//   RdValid      out  1        1-cycle pulse, RdData valid
//   Err          out  1        sticky; set on timeout
//   MulSt        out  1        start pulse to multiplier
//   MulMultiplicando out WIDTH to multiplier
//   MulMultiplicador out WIDTH to multiplier
//   MulIdle      in   1        multiplier idle
//   MulDone      in   1        multiplier finished; MulProduto valid this cycle
//   MulProduto   in   2*WIDTH  product
// BEHAVIOUR
//   - Reset values: FSM=IDLE, HI=LO=0, RdData=0, RdValid=0, Err=0, MulSt=0, Mul operands=0, timeout cnt=0.
//   - Stall is combinational: Stall = OpValid & (OpCode in 1..5) & (state != IDLE).
//   - An op is accepted on a clock edge where OpValid=1 and Stall=0.
//   - FSM states:
//     - IDLE:
//       - MULT: latch OpA/OpB into Mul operands, -> ISSUE.
//       - MFHI/MFLO: next edge RdData<=HI/LO, RdValid<=1 (latency 1).
//       - MTHI/MTLO: next edge HI/LO<=OpA.
//     - ISSUE: MulSt=1 (registered) only in a cycle where MulIdle=1, then -> WAIT.
//       - If MulIdle=0, hold ISSUE with MulSt=0; no cycle limit.
//     - WAIT: MulSt=0; count cycles.
//       - MulDone=1: {HI,LO}<=MulProduto (sign fix-up if enabled), cnt<=0, -> IDLE.
//       - cnt reaches TIMEOUT_CYCLES-1 with no MulDone: Err<=1, HI/LO unchanged, -> IDLE.
//   - MulSt is high for exactly one cycle per MULT.
//   - The multiplier's operands are held stable from the ISSUE entry edge until the WAIT exit edge.
//   - Done and an op in the same cycle: the op is stalled that cycle and accepted the next cycle.
//     - MFLO issued during a MULT therefore returns the new LO.
//   - Back-to-back MULT: the second MULT is accepted the cycle after the Done edge and re-enters ISSUE.
//   - MulDone seen outside WAIT: ignored.
//   - Rst mid-op: immediate return to IDLE; HI/LO cleared; Err cleared; the in-flight product is discarded.
//   - RdValid returns to 0 the cycle after its pulse; RdData holds its last value.
// CONFIGURATION
//   MULT_SIGNED_EN defined:
//     - MULT treats OpA/OpB as two's complement; magnitudes go to the multiplier.
//     - -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
//     - The product is negated at capture when the operand signs differ (sign latched at accept).
//   MULT_SIGNED_EN undefined:
//     - Unsigned only; operands pass straight through; no sign logic synthesized.
// TESTING
//   1. Rst, MULT 11*13 -> MulSt single pulse, Stall during op; after Done HI=0x0000, LO=0x008F.
//      MFLO -> RdData=0x008F with RdValid 1 cycle later.
//   2. MULT 2001*4001 then MFHI issued during WAIT -> Stall until the cycle after Done.
//      RdData=0x007A; then MFLO -> 0x2971.
//   3. MULT 65535*65535 -> HI=0xFFFE, LO=0x0001 (unsigned).
//      With MULT_SIGNED_EN (-1*-1): HI=0x0000, LO=0x0001.
//   4. MULT 0xFFFE*3 -> without macro HI=0x0002, LO=0xFFFA; with MULT_SIGNED_EN HI=0xFFFF, LO=0xFFFA.
//   5. MTHI 0x1234, MTLO 0xABCD, MFHI, MFLO -> no Stall; reads return 0x1234 then 0xABCD.
//      Hold MulIdle=0 during a MULT -> state stays ISSUE, no MulSt.
//   6. Timeout and reset:
//      - Hold MulDone=0 -> after 64 WAIT cycles Err=1, HI/LO unchanged, Stall drops.
//      - Assert Rst mid-WAIT -> all outputs to reset values within the same cycle.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
// =============================================================================
// Module      : mult_hilo_ctrl
// Description : MIPS HI/LO front end that drives a sequential shift-add multiplier.
//               Optional macro MULT_SIGNED_EN adds signed MULT support.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mult_hilo_ctrl #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 OpValid,
    input  logic [2:0]           OpCode,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    output logic                 Stall,
    output logic [WIDTH-1:0]     RdData,
    output logic                 RdValid,
    output logic                 Err,
    output logic                 MulSt,
    output logic [WIDTH-1:0]     MulMultiplicando,
    output logic [WIDTH-1:0]     MulMultiplicador,
    input  logic                 MulIdle,
    input  logic                 MulDone,
    input  logic [2*WIDTH-1:0]   MulProduto
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MFHI = 3'd2;
    localparam logic [2:0] OP_MFLO = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                 state_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;
    logic [WIDTH-1:0]       rd_data_q;
    logic                   rd_valid_q;
    logic                   err_q;
    logic                   mul_st_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [7:0]             cnt_q;

    logic                   is_ctrl_op;
    logic                   accept;
    logic [WIDTH-1:0]       mcand_d;
    logic [WIDTH-1:0]       mplier_d;
    logic [2*WIDTH-1:0]     prod_d;

    assign is_ctrl_op = (OpCode >= OP_MULT) && (OpCode <= OP_MTLO);
    assign Stall      = OpValid & is_ctrl_op & (state_q != S_IDLE);
    assign accept     = OpValid & is_ctrl_op & (state_q == S_IDLE);

`ifdef MULT_SIGNED_EN
    logic neg_q;

    // Two's-complement negation maps the most negative value onto its unsigned magnitude.
    assign mcand_d  = OpA[WIDTH-1] ? (~OpA + 1'b1) : OpA;
    assign mplier_d = OpB[WIDTH-1] ? (~OpB + 1'b1) : OpB;
    assign prod_d   = neg_q ? (~MulProduto + 1'b1) : MulProduto;
`else
    assign mcand_d  = OpA;
    assign mplier_d = OpB;
    assign prod_d   = MulProduto;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            mul_st_q   <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
`ifdef MULT_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
            mul_st_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (OpCode)
                            OP_MULT: begin
                                mcand_q  <= mcand_d;
                                mplier_q <= mplier_d;
`ifdef MULT_SIGNED_EN
                                neg_q    <= OpA[WIDTH-1] ^ OpB[WIDTH-1];
`endif
                                state_q  <= S_ISSUE;
                            end
                            OP_MFHI: begin
                                rd_data_q  <= hi_q;
                                rd_valid_q <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data_q  <= lo_q;
                                rd_valid_q <= 1'b1;
                            end
                            OP_MTHI: hi_q <= OpA;
                            OP_MTLO: lo_q <= OpA;
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    // A busy multiplier may hold us here indefinitely; only the WAIT phase is timed.
                    if (MulIdle) begin
                        mul_st_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (MulDone) begin
                        {hi_q, lo_q} <= prod_d;
                        cnt_q        <= '0;
                        state_q      <= S_IDLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RdData           = rd_data_q;
    assign RdValid          = rd_valid_q;
    assign Err              = err_q;
    assign MulSt            = mul_st_q;
    assign MulMultiplicando = mcand_q;
    assign MulMultiplicador = mplier_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
// =============================================================================
// Module      : tb_mult_hilo_ctrl
// Description : Self-checking bench for mult_hilo_ctrl with a behavioural HI/LO model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mult_hilo_ctrl;
    localparam int W = 16;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic           OpValid = 1'b0;
    logic [2:0]     OpCode = 3'd0;
    logic [W-1:0]   OpA = '0;
    logic [W-1:0]   OpB = '0;
    logic           Stall;
    logic [W-1:0]   RdData;
    logic           RdValid;
    logic           Err;
    logic           MulSt;
    logic [W-1:0]   MulMultiplicando;
    logic [W-1:0]   MulMultiplicador;
    logic           MulIdle = 1'b1;
    logic           MulDone = 1'b0;
    logic [2*W-1:0] MulProduto = '0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_rd = '0;
    logic         m_err = 1'b0;

    mult_hilo_ctrl dut (
        .Clk(Clk), .Rst(Rst), .OpValid(OpValid), .OpCode(OpCode), .OpA(OpA), .OpB(OpB),
        .Stall(Stall), .RdData(RdData), .RdValid(RdValid), .Err(Err), .MulSt(MulSt),
        .MulMultiplicando(MulMultiplicando), .MulMultiplicador(MulMultiplicador),
        .MulIdle(MulIdle), .MulDone(MulDone), .MulProduto(MulProduto)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
`ifdef MULT_SIGNED_EN
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        return v[W-1:0];
`else
        return x;
`endif
    endfunction

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
`ifdef MULT_SIGNED_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        return p[2*W-1:0];
    endfunction

    task automatic do_read(input logic [2:0] op, input logic [W-1:0] exp);
        OpValid = 1'b1; OpCode = op; OpA = W'($urandom);
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL read_stall: got %b expected 0", Stall); end
        tick;
        OpValid = 1'b0; OpCode = 3'd0;
        checks++;
        if (RdValid !== 1'b1 || RdData !== exp) begin
            errors++;
            $display("FAIL read_data op%0d: got valid=%b data=%h expected valid=1 data=%h", op, RdValid, RdData, exp);
        end
        m_rd = exp;
        tick;
        checks++;
        if (RdValid !== 1'b0 || RdData !== m_rd) begin
            errors++;
            $display("FAIL read_hold: got valid=%b data=%h expected valid=0 data=%h", RdValid, RdData, m_rd);
        end
    endtask

    task automatic do_write(input logic [2:0] op, input logic [W-1:0] val);
        OpValid = 1'b1; OpCode = op; OpA = val;
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL write_stall: got %b expected 0", Stall); end
        tick;
        OpValid = 1'b0; OpCode = 3'd0;
        if (op == 3'd4) m_hi = val; else m_lo = val;
        checks++;
        if (RdValid !== 1'b0) begin errors++; $display("FAIL write_rdvalid: got %b expected 0", RdValid); end
    endtask

    // rd_op 0: nothing queued; 2/3: MFHI/MFLO presented during the multiply
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int idle_wait, input int lat, input logic [2:0] rd_op);
        logic [2*W-1:0] exp_p;
        logic [2*W-1:0] raw;
        logic           exp_stall;
        exp_p     = ref_prod(a, b);
        raw       = {{W{1'b0}}, mag(a)} * {{W{1'b0}}, mag(b)};
        exp_stall = (rd_op != 3'd0);
        OpValid = 1'b1; OpCode = 3'd1; OpA = a; OpB = b;
        #1;
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL mult_accept_stall: got %b expected 0", Stall); end
        tick;
        OpA = W'($urandom); OpB = W'($urandom);
        OpValid = exp_stall; OpCode = rd_op;
        MulIdle = (idle_wait == 0);
        for (int i = 0; i < idle_wait; i++) begin
            tick;
            checks++;
            if (MulSt !== 1'b0 || Stall !== exp_stall) begin
                errors++;
                $display("FAIL issue_hold: got st=%b stall=%b expected st=0 stall=%b", MulSt, Stall, exp_stall);
            end
        end
        MulIdle = 1'b1;
        tick;
        checks++;
        if (MulSt !== 1'b1 || MulMultiplicando !== mag(a) || MulMultiplicador !== mag(b)) begin
            errors++;
            $display("FAIL mul_start: got st=%b a=%h b=%h expected st=1 a=%h b=%h",
                     MulSt, MulMultiplicando, MulMultiplicador, mag(a), mag(b));
        end
        for (int i = 0; i < lat; i++) begin
            tick;
            checks++;
            if (MulSt !== 1'b0 || Stall !== exp_stall || MulMultiplicando !== mag(a) || MulMultiplicador !== mag(b)) begin
                errors++;
                $display("FAIL wait_phase: got st=%b stall=%b a=%h b=%h expected st=0 stall=%b a=%h b=%h",
                         MulSt, Stall, MulMultiplicando, MulMultiplicador, exp_stall, mag(a), mag(b));
            end
        end
        MulDone = 1'b1; MulProduto = raw;
        #1;
        checks++;
        if (Stall !== exp_stall) begin errors++; $display("FAIL done_stall: got %b expected %b", Stall, exp_stall); end
        tick;
        MulDone = 1'b0; MulProduto = $urandom;
        m_hi = exp_p[2*W-1:W];
        m_lo = exp_p[W-1:0];
        checks++;
        if (MulSt !== 1'b0 || Err !== m_err || Stall !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got st=%b err=%b stall=%b expected st=0 err=%b stall=0", MulSt, Err, Stall, m_err);
        end
        if (exp_stall) begin
            tick;
            OpValid = 1'b0; OpCode = 3'd0;
            m_rd = (rd_op == 3'd2) ? m_hi : m_lo;
            checks++;
            if (RdValid !== 1'b1 || RdData !== m_rd) begin
                errors++;
                $display("FAIL read_after_mult: got valid=%b data=%h expected valid=1 data=%h", RdValid, RdData, m_rd);
            end
        end else begin
            OpValid = 1'b0; OpCode = 3'd0;
        end
    endtask

    task automatic test_reset;
        OpValid = 1'b1; OpCode = 3'd2;
        repeat (2) tick;
        checks++;
        if (Stall !== 1'b0 || RdData !== '0 || RdValid !== 1'b0 || Err !== 1'b0 || MulSt !== 1'b0 ||
            MulMultiplicando !== '0 || MulMultiplicador !== '0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b rd=%h rv=%b err=%b st=%b a=%h b=%h expected all zero",
                     Stall, RdData, RdValid, Err, MulSt, MulMultiplicando, MulMultiplicador);
        end
        OpValid = 1'b0; OpCode = 3'd0;
        Rst = 1'b0;
        tick;
        do_read(3'd2, 16'h0000);
        do_read(3'd3, 16'h0000);
    endtask

    task automatic test_directed;
        run_mult(16'd11, 16'd13, 0, 3, 3'd0);
        do_read(3'd2, 16'h0000);
        do_read(3'd3, 16'h008F);
        run_mult(16'd2001, 16'd4001, 1, 4, 3'd2);
        checks++;
        if (RdData !== 16'h007A) begin errors++; $display("FAIL mfhi_during_wait: got %h expected 007a", RdData); end
        do_read(3'd3, 16'h2971);
        run_mult(16'hFFFF, 16'hFFFF, 0, 2, 3'd0);
`ifdef MULT_SIGNED_EN
        do_read(3'd2, 16'h0000);
`else
        do_read(3'd2, 16'hFFFE);
`endif
        do_read(3'd3, 16'h0001);
        run_mult(16'hFFFE, 16'd3, 0, 1, 3'd3);
`ifdef MULT_SIGNED_EN
        do_read(3'd2, 16'hFFFF);
`else
        do_read(3'd2, 16'h0002);
`endif
        do_read(3'd3, 16'hFFFA);
        do_write(3'd4, 16'h1234);
        do_write(3'd5, 16'hABCD);
        do_read(3'd2, 16'h1234);
        do_read(3'd3, 16'hABCD);
        run_mult(16'd5, 16'd7, 4, 1, 3'd3);
        do_read(3'd2, m_hi);
    endtask

    task automatic test_back_to_back;
        run_mult(16'h8000, 16'h0002, 0, 0, 3'd0);
        run_mult(16'h1357, 16'h2468, 0, 2, 3'd0);
        do_read(3'd2, m_hi);
        do_read(3'd3, m_lo);
    endtask

    task automatic test_random;
        logic [2:0] nop_codes [3];
        int kind;
        logic [W-1:0] a;
        logic [W-1:0] b;
        nop_codes[0] = 3'd0; nop_codes[1] = 3'd6; nop_codes[2] = 3'd7;
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(0, 6));
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            case (kind)
                0: begin
                    OpValid = 1'($urandom_range(0, 1));
                    OpCode  = nop_codes[$urandom_range(0, 2)];
                    OpA = a;
                    tick;
                    OpValid = 1'b0; OpCode = 3'd0;
                    checks++;
                    if (RdValid !== 1'b0 || RdData !== m_rd) begin
                        errors++;
                        $display("FAIL nop: got rv=%b rd=%h expected rv=0 rd=%h", RdValid, RdData, m_rd);
                    end
                end
                1: run_mult(a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                            ($urandom_range(0, 2) == 0) ? 3'd0 : 3'(2 + $urandom_range(0, 1)));
                2: do_read(3'd2, m_hi);
                3: do_read(3'd3, m_lo);
                4: do_write(3'd4, a);
                5: do_write(3'd5, a);
                default: begin
                    MulDone = 1'b1; MulProduto = $urandom;
                    tick;
                    MulDone = 1'b0;
                    checks++;
                    if (MulSt !== 1'b0 || RdValid !== 1'b0) begin
                        errors++;
                        $display("FAIL spurious_done: got st=%b rv=%b expected 0 0", MulSt, RdValid);
                    end
                end
            endcase
        end
        do_read(3'd2, m_hi);
        do_read(3'd3, m_lo);
    endtask

    task automatic test_timeout;
        OpValid = 1'b1; OpCode = 3'd1; OpA = 16'd3; OpB = 16'd4;
        tick;
        OpCode = 3'd3;
        tick;
        checks++;
        if (MulSt !== 1'b1) begin errors++; $display("FAIL timeout_start: got %b expected 1", MulSt); end
        for (int i = 1; i < 64; i++) begin
            tick;
            checks++;
            if (Stall !== 1'b1 || Err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: got stall=%b err=%b expected 1 0", i, Stall, Err);
            end
        end
        tick;
        m_err = 1'b1;
        checks++;
        if (Stall !== 1'b0 || Err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: got stall=%b err=%b expected 0 1", Stall, Err);
        end
        tick;
        OpValid = 1'b0; OpCode = 3'd0;
        m_rd = m_lo;
        checks++;
        if (RdValid !== 1'b1 || RdData !== m_lo) begin
            errors++;
            $display("FAIL timeout_lo_kept: got rv=%b rd=%h expected 1 %h", RdValid, RdData, m_lo);
        end
        do_read(3'd2, m_hi);
        do_write(3'd4, 16'h5A5A);
        checks++;
        if (Err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", Err); end
    endtask

    task automatic test_reset_mid;
        OpValid = 1'b1; OpCode = 3'd1; OpA = 16'h1111; OpB = 16'h0202;
        tick;
        OpCode = 3'd2;
        repeat (4) tick;
        checks++;
        if (Stall !== 1'b1 || MulMultiplicando !== mag(16'h1111)) begin
            errors++;
            $display("FAIL pre_reset: got stall=%b a=%h expected 1 %h", Stall, MulMultiplicando, mag(16'h1111));
        end
        MulDone = 1'b0;
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b0 || RdData !== '0 || RdValid !== 1'b0 || Err !== 1'b0 || MulSt !== 1'b0 ||
            MulMultiplicando !== '0 || MulMultiplicador !== '0) begin
            errors++;
            $display("FAIL reset_mid: got stall=%b rd=%h rv=%b err=%b st=%b a=%h b=%h expected all zero",
                     Stall, RdData, RdValid, Err, MulSt, MulMultiplicando, MulMultiplicador);
        end
        OpValid = 1'b0; OpCode = 3'd0;
        MulDone = 1'b1; MulProduto = 32'hDEAD_BEEF;
        #1 Rst = 1'b0;
        tick;
        MulDone = 1'b0;
        m_hi = '0; m_lo = '0; m_rd = '0; m_err = 1'b0;
        do_read(3'd2, 16'h0000);
        do_read(3'd3, 16'h0000);
        checks++;
        if (Err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", Err); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_random;
        test_timeout;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
